// File: rtl/zpu_sd_pkg.sv
// Shared types and bit positions for the ZPU <-> hps_io multi-drive SD bridge.
// The state enum, control-word and status-word bit indices, and the mount arbitration helper.
package zpu_sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } sd_state_t;

    // ZPU_OUT2 control word
    localparam int LBA_SEL = 0;
    localparam int BLK_RD  = 1;
    localparam int BLK_WR  = 2;
    localparam int DRV_LSB = 4;

    // ZPU_IN2 status word
    localparam int STS_IO_DONE      = 0;
    localparam int STS_MOUNTED      = 1;
    localparam int STS_FILENO_LSB   = 2;
    localparam int STS_FILETYPE_LSB = 5;
    localparam int STS_READONLY     = 7;
    localparam int STS_BUSY         = 8;
    localparam int STS_TMO_ERR      = 9;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/zpu_sd_bridge_sector_dpram.sv
// Shared sector buffer: true dual-port byte RAM, port A toward hps_io, port B toward the ZPU.
// Reads are registered (1-cycle latency) and return the old data on a same-address write.
module sector_dpram
    import zpu_sd_pkg::*;
#(
    parameter int SECTOR_AW = 9
) (
    input  logic                 i_clk,
    input  logic [SECTOR_AW-1:0] i_addr_a,
    input  logic                 i_we_a,
    input  logic [7:0]           i_din_a,
    output logic [7:0]           o_dout_a,
    input  logic [SECTOR_AW-1:0] i_addr_b,
    input  logic                 i_we_b,
    input  logic [7:0]           i_din_b,
    output logic [7:0]           o_dout_b
);

    logic [7:0] r_mem [0:(1<<SECTOR_AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we_a) r_mem[i_addr_a] <= i_din_a;
        if (i_we_b) r_mem[i_addr_b] <= i_din_b;
        o_dout_a <= r_mem[i_addr_a];
        o_dout_b <= r_mem[i_addr_b];
    end

endmodule

// File: rtl/zpu_sd_bridge.sv
// ZPU <-> hps_io block-I/O bridge for NUM_DRIVES images sharing one sector buffer.
// Optional watchdog on stalled requests: define ZPU_SD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no request outstanding, waiting for a blk_rd/blk_wr rising edge
// REQ   | sd_rd/sd_wr raised toward hps_io, waiting for sd_ack of the latched drive
// XFER  | hps_io moving the sector, waiting for sd_ack to fall
module zpu_sd_bridge
    import zpu_sd_pkg::*;
#(
    parameter int          NUM_DRIVES  = 4,
    parameter int          SECTOR_AW   = 9,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [31:0]             ZPU_OUT2,
    input  logic [31:0]             ZPU_OUT3,
    input  logic                    ZPU_DATA_WR,
    input  logic                    ZPU_DATA_RD,
    input  logic                    ZPU_IO_WR,
    output logic [15:0]             ZPU_IN2,
    output logic [31:0]             ZPU_IN3,
    output logic [32*NUM_DRIVES-1:0] sd_lba,
    output logic [NUM_DRIVES-1:0]   sd_rd,
    output logic [NUM_DRIVES-1:0]   sd_wr,
    input  logic [NUM_DRIVES-1:0]   sd_ack,
    input  logic [SECTOR_AW-1:0]    sd_buff_addr,
    input  logic [7:0]              sd_buff_dout,
    output logic [7:0]              sd_buff_din,
    input  logic                    sd_buff_wr,
    input  logic [NUM_DRIVES-1:0]   img_mounted,
    input  logic [63:0]             img_size,
    input  logic [7:0]              img_index
);

    logic                         r_dwr_s1, r_dwr_s2, r_drd_s1, r_wr_inc;
    logic [1:0]                   r_blk_q;
    logic [SECTOR_AW-1:0]         r_ptr;
    logic [NUM_DRIVES-1:0][31:0]  r_lba;
    sd_state_t                    r_state, w_state_nxt;
    logic [NUM_DRIVES-1:0]        r_drv_oh, w_drv_oh;
    logic                         r_req_rd, r_req_wr, r_io_done, r_busy, r_tmo_err;
    logic [NUM_DRIVES-1:0]        r_mnt_q, r_pending, w_pending_nxt, w_mnt_rise, w_svc_oh;
    logic                         r_mounted, r_readonly;
    logic [2:0]                   r_fileno, w_svc_idx;
    logic [1:0]                   r_filetype;
    logic [31:0]                  r_filesize;
    logic [15:0]                  w_status;
    logic [7:0]                   w_ram_q;

    logic [2:0] w_drv;
    logic       w_lba_sel, w_dwr_fire, w_buf_we, w_drd_fall, w_rd_rise, w_wr_rise;
    logic       w_drv_ok, w_ack_d, w_accept, w_bad, w_done, w_tmo, w_tmo_hit;

    assign w_drv      = ZPU_OUT2[DRV_LSB +: 3];
    assign w_lba_sel  = ZPU_OUT2[LBA_SEL];
    assign w_dwr_fire = r_dwr_s1 & ~r_dwr_s2;
    assign w_buf_we   = w_dwr_fire & ~w_lba_sel;
    assign w_drd_fall = r_drd_s1 & ~ZPU_DATA_RD;
    assign w_rd_rise  = ZPU_OUT2[BLK_RD] & ~r_blk_q[0];
    assign w_wr_rise  = ZPU_OUT2[BLK_WR] & ~r_blk_q[1];
    assign w_drv_ok   = int'(w_drv) < NUM_DRIVES;
    assign w_ack_d    = |(sd_ack & r_drv_oh);

    always_comb begin
        w_drv_oh = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (w_drv == 3'(i)) w_drv_oh[i] = 1'b1;
        end
    end

    // ---------------- ZPU strobes, buffer pointer, LBA registers ----------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dwr_s1 <= 1'b0;
            r_dwr_s2 <= 1'b0;
            r_drd_s1 <= 1'b0;
            r_wr_inc <= 1'b0;
            r_ptr    <= '0;
            r_lba    <= '0;
        end else begin
            r_dwr_s1 <= ZPU_DATA_WR;
            r_dwr_s2 <= r_dwr_s1;
            r_drd_s1 <= ZPU_DATA_RD;
            r_wr_inc <= w_buf_we;
            if (ZPU_IO_WR)
                r_ptr <= '0;
            else
                r_ptr <= r_ptr + SECTOR_AW'(r_wr_inc) + SECTOR_AW'(w_drd_fall);
            if (w_dwr_fire && w_lba_sel) begin
                for (int i = 0; i < NUM_DRIVES; i++) begin
                    if (w_drv_oh[i]) r_lba[i] <= ZPU_OUT3;
                end
            end
        end
    end

    sector_dpram #(.SECTOR_AW(SECTOR_AW)) u_buf (
        .i_clk    (CLK),
        .i_addr_a (sd_buff_addr),
        .i_we_a   (sd_buff_wr),
        .i_din_a  (sd_buff_dout),
        .o_dout_a (sd_buff_din),
        .i_addr_b (r_ptr),
        .i_we_b   (w_buf_we),
        .i_din_b  (ZPU_OUT3[7:0]),
        .o_dout_b (w_ram_q)
    );

    // ---------------- watchdog ----------------
`ifdef ZPU_SD_TIMEOUT_EN
    logic [23:0] r_tmo_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_tmo_cnt <= '0;
        else if (r_state == ST_IDLE)
            r_tmo_cnt <= TIMEOUT_CYC - 24'd1;
        else if (r_tmo_cnt != '0)
            r_tmo_cnt <= r_tmo_cnt - 24'd1;
    end

    assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo_cnt == '0);
`else
    logic [23:0] w_unused_tmo;
    assign w_unused_tmo = TIMEOUT_CYC;
    assign w_tmo_hit    = 1'b0;
`endif

    // ---------------- request FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_bad       = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_rise || w_wr_rise) begin
                    if (w_drv_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (w_tmo_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_ack_d) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_tmo_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!w_ack_d) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_blk_q   <= '0;
            r_drv_oh  <= '0;
            r_req_rd  <= 1'b0;
            r_req_wr  <= 1'b0;
            r_io_done <= 1'b0;
            r_busy    <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_blk_q <= ZPU_OUT2[BLK_WR:BLK_RD];
            if (w_accept) begin
                r_drv_oh  <= w_drv_oh;
                r_req_rd  <= w_rd_rise;
                r_req_wr  <= ~w_rd_rise;
                r_io_done <= 1'b0;
                r_busy    <= 1'b1;
                r_tmo_err <= 1'b0;
            end else if (w_state_nxt != ST_REQ) begin
                r_req_rd <= 1'b0;
                r_req_wr <= 1'b0;
            end
            if (w_bad || w_done || w_tmo) r_io_done <= 1'b1;
            if (w_done || w_tmo)          r_busy    <= 1'b0;
            if (w_tmo)                    r_tmo_err <= 1'b1;
        end
    end

    // The ack masks the request combinationally so sd_rd/sd_wr fall in the ack's first cycle.
    assign sd_rd  = {NUM_DRIVES{r_req_rd}} & r_drv_oh & ~sd_ack;
    assign sd_wr  = {NUM_DRIVES{r_req_wr}} & r_drv_oh & ~sd_ack;
    assign sd_lba = r_lba;

    // ---------------- mount capture ----------------
    always_comb begin
        w_mnt_rise = img_mounted & ~r_mnt_q;
        w_svc_idx  = lowest_set(8'(r_pending));
        w_svc_oh   = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (w_svc_idx == 3'(i)) w_svc_oh[i] = 1'b1;
        end
        w_pending_nxt = (r_pending & ~w_svc_oh) | w_mnt_rise;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mnt_q    <= '0;
            r_pending  <= '0;
            r_mounted  <= 1'b0;
            r_readonly <= 1'b0;
            r_fileno   <= '0;
            r_filetype <= '0;
            r_filesize <= '0;
        end else begin
            r_mnt_q   <= img_mounted;
            r_pending <= w_pending_nxt;
            if (|r_pending) begin
                r_fileno   <= w_svc_idx;
                r_filetype <= img_index[7:6];
                r_readonly <= 1'b1;
                r_mounted  <= ~r_mounted;
                r_filesize <= img_size[31:0];
            end
        end
    end

    // ---------------- ZPU read-back ----------------
    always_comb begin
        w_status                                = '0;
        w_status[STS_IO_DONE]                   = r_io_done;
        w_status[STS_MOUNTED]                   = r_mounted;
        w_status[STS_FILENO_LSB +: 3]           = r_fileno;
        w_status[STS_FILETYPE_LSB +: 2]         = r_filetype;
        w_status[STS_READONLY]                  = r_readonly;
        w_status[STS_BUSY]                      = r_busy;
        w_status[STS_TMO_ERR]                   = r_tmo_err;
    end

    assign ZPU_IN2 = w_status;
    assign ZPU_IN3 = w_lba_sel ? r_filesize : {24'd0, w_ram_q};

    logic w_unused;
    assign w_unused = &{1'b0, ZPU_OUT2[31:7], ZPU_OUT2[3], img_size[63:32], img_index[5:0]};

endmodule

// File: doc/zpu_sd_bridge.md
Name: zpu_sd_bridge

Overview:
Multi-drive successor to the single-drive ZPU↔hps_io block-I/O glue. It lets the ZPU firmware drive SD block transfers on NUM_DRIVES mounted images through one shared sector buffer. The block provides:
- an LBA register per drive;
- a request/ack state machine toward hps_io;
- mount-event capture with arbitration.

It sits between the ZPU register ports and the hps_io sd_* interface, inside the core top level.

Parameters:
NUM_DRIVES, 4, number of hps_io image slots; 1..8.
SECTOR_AW, 9, sector buffer address width; buffer depth is 2**SECTOR_AW bytes (512 default, 10 selects 1024).
TIMEOUT_CYC, 24'd5000000, watchdog limit in CLK cycles; used only when ZPU_SD_TIMEOUT_EN is defined.

Ports:
CLK  in  1  system clock; all logic is in this domain.
RESET_N  in  1  asynchronous active-low reset.
ZPU_OUT2  in  32  control word: [0] lba_sel, [1] blk_rd, [2] blk_wr, [6:4] drive select.
ZPU_OUT3  in  32  write data: LBA when lba_sel=1, otherwise byte [7:0].
ZPU_DATA_WR  in  1  data write strobe, level (ZPU_WR[6]).
ZPU_DATA_RD  in  1  data read strobe, level (ZPU_RD[2]).
ZPU_IO_WR  in  1  control write pulse (ZPU_WR[5]); clears the buffer pointer.
ZPU_IN2  out  16  status: [0] io_done, [1] mounted toggle, [4:2] fileno, [6:5] filetype, [7] readonly, [8] busy, [9] timeout_err, [15:10] zero.
ZPU_IN3  out  32  lba_sel ? filesize : {24'b0, buffer byte}.
sd_lba  out  32*NUM_DRIVES  per-drive LBA, packed with drive 0 in the LSBs.
sd_rd  out  NUM_DRIVES  read request, one-hot.
sd_wr  out  NUM_DRIVES  write request, one-hot.
sd_ack  in  NUM_DRIVES  hps_io acknowledge.
sd_buff_addr  in  SECTOR_AW  hps_io buffer address.
sd_buff_dout  in  8  hps_io write data.
sd_buff_din  out  8  buffer read data, broadcast to all drives.
sd_buff_wr  in  1  hps_io buffer write enable.
img_mounted  in  NUM_DRIVES  mount pulses.
img_size  in  64  size of the most recently mounted image.
img_index  in  8  ioctl index; bits [7:6] give the file type.

Behaviour:
Reset:
- All outputs and registers are 0: sd_rd, sd_wr, sd_lba, io_done, mounted, fileno, filetype, readonly, busy, timeout_err, pointer, pending.
- Reset mid-transfer drops the request immediately; a late sd_ack is then ignored.

Strobe handling:
- ZPU_DATA_WR is registered twice. The action fires on the cycle where stage1=1 and stage2=0, i.e. 2 cycles after the rising edge.
- lba_sel=1: sd_lba[drive select] <= ZPU_OUT3.
- lba_sel=0: one-cycle buffer write at the pointer; the pointer increments the following cycle.
- ZPU_DATA_RD falling edge (one registered stage): pointer +1.
- The pointer wraps modulo 2**SECTOR_AW.
- ZPU_IO_WR sets the pointer to 0 and has priority over both increments in the same cycle.
- Buffer read latency is 1 cycle; ZPU_IN3 is valid 1 cycle after a pointer change.

FSM: IDLE, REQ, XFER.
- IDLE: a rising edge of blk_rd or blk_wr latches the drive, clears io_done, asserts sd_rd[d] or sd_wr[d], sets busy, and moves to REQ.
- If blk_rd and blk_wr rise together, read wins.
- Drive select ≥ NUM_DRIVES is ignored: no request is made and io_done is set to 1 next cycle.
- REQ: when sd_ack[d]=1, drop sd_rd/sd_wr the same cycle and move to XFER.
- XFER: on the falling edge of sd_ack[d], set io_done=1, clear busy, and return to IDLE.
- New blk edges in REQ or XFER are ignored.
- Acks on other drives are ignored.

Mount capture:
- A rising edge of img_mounted[i] sets pending[i].
- In any cycle with pending≠0, service the lowest set index i:
  - fileno <= i, filetype <= img_index[7:6], readonly <= 1;
  - mounted toggles, filesize <= img_size[31:0];
  - clear pending[i].
- One mount is serviced per cycle, so simultaneous mounts produce consecutive toggles.

Optional Feature:
ZPU_SD_TIMEOUT_EN
- Defined: a 24-bit counter runs while the FSM is in REQ or XFER and clears in IDLE. On reaching TIMEOUT_CYC it:
  - drops the requests;
  - sets timeout_err=1 and io_done=1;
  - returns to IDLE.
- timeout_err clears on the next accepted blk edge.
- Undefined: no counter is built, ZPU_IN2[9]=0, and the FSM waits for ack indefinitely.

Decomposition:
Package zpu_sd_pkg holds:
- the FSM state enum (IDLE/REQ/XFER);
- control bit-index constants (LBA_SEL=0, BLK_RD=1, BLK_WR=2, DRV_LSB=4);
- status bit-index constants.

One sub-module, sector_dpram (true dual-port RAM, parameter SECTOR_AW, 8-bit data):
- port A serves hps_io;
- port B serves the ZPU pointer.

Test Plan:
- Write LBA 0x00001234 with drive select=2 → sd_lba[95:64]=0x00001234; other slots unchanged.
- Drive select=1, blk_rd edge → sd_rd=4'b0010 next cycle, busy=1. Then sd_ack high for 512 cycles with writes 0..511 of i&0xFF, then low → sd_rd drops the cycle ack rises; io_done=1 one cycle after ack falls. ZPU_IO_WR then 4 read strobes → ZPU_IN3 = 0,1,2,3.
- 513 ZPU byte writes with SECTOR_AW=9 → byte 513 overwrites address 0 (wrap).
- img_mounted=4'b1010 in one cycle with img_size=0x8000 → two toggles of mounted on consecutive cycles; fileno ends at 3; ZPU_IN3 with lba_sel=1 returns 0x00008000.
- Drive select=5 with NUM_DRIVES=4, blk_wr edge → no sd_wr asserted; io_done=1.
- With ZPU_SD_TIMEOUT_EN and TIMEOUT_CYC=100, no ack → sd_rd drops at cycle 100; ZPU_IN2[9]=1 and [0]=1.
